// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode seven-segment display.
// One shared decoder, shadow digit register loaded at frame boundaries, blanking between digits.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    upd_req,
  output logic                    upd_ack,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              hex_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDXW = $clog2(NUM_DIGITS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNTW = $clog2(CMAX);

  typedef enum logic [0:0] {S_BLANK = 1'b0, S_ON = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]              seg_q, seg_d;
  logic                    ack_q, ack_d;
  logic                    frame_q, frame_d;

  // Digit is dark when masked, or when it is a leading zero (digit 0 always shows).
  function automatic logic digit_dark(input logic [4*NUM_DIGITS-1:0] sh,
                                      input logic [IDXW-1:0]         ix,
                                      input logic                    lz,
                                      input logic [NUM_DIGITS-1:0]   mask);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      upper_zero = upper_zero & ((k < int'(ix)) | (sh[4*k +: 4] == 4'h0));
    end
    return mask[ix] | (lz & (ix != '0) & upper_zero);
  endfunction

  assign hex_out    = shadow_q[{idx_q, 2'b00} +: 4];
  assign an_n       = an_n_q;
  assign seg_out    = seg_q;
  assign upd_ack    = ack_q;
  assign frame_done = frame_q;

  // Next-state logic: blank/dwell sequencing, digit capture and frame-boundary reload.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    an_n_d   = an_n_q;
    seg_d    = seg_q;
    ack_d    = 1'b0;
    frame_d  = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == CNTW'(BLANK - 1)) begin
          state_d = S_ON;
          cnt_d   = '0;
          an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
          if (digit_dark(shadow_q, idx_q, lz_en, blank_mask)) begin
            seg_d = 7'h7F;
          end else begin
            seg_d = seg_in;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_ON: begin
        if (cnt_q == CNTW'(DWELL - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          an_n_d  = '1;
          seg_d   = 7'h7F;
          if (idx_q == IDXW'(NUM_DIGITS - 1)) begin
            // Frame boundary: the only edge where digits_in may be taken.
            idx_d   = '0;
            frame_d = 1'b1;
            if (upd_req) begin
              shadow_d = digits_in;
              ack_d    = 1'b1;
            end else begin
              shadow_d = shadow_q;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
        idx_d   = '0;
        cnt_d   = '0;
        an_n_d  = '1;
        seg_d   = 7'h7F;
      end
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BLANK;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      an_n_q   <= '1;
      seg_q    <= 7'h7F;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      an_n_q   <= an_n_d;
      seg_q    <= seg_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a cycle-position model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seg_scan_ctrl;

  localparam int ND = 6;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int SLOT = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   digits_in = 24'h0;
  logic          upd_req = 1'b0;
  logic          upd_ack;
  logic          lz_en = 1'b0;
  logic [ND-1:0] blank_mask = '0;
  logic [3:0]    hex_out;
  logic [6:0]    seg_in;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_n;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .upd_req(upd_req),
    .upd_ack(upd_ack), .lz_en(lz_en), .blank_mask(blank_mask), .hex_out(hex_out),
    .seg_in(seg_in), .seg_out(seg_out), .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign seg_in = dec(hex_out);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: position in the frame follows from the edge count since reset release.
  int          m_e;
  logic [23:0] m_sh;
  logic [5:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_ack, m_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; m_sh = 24'h0; m_an = 6'h3F; m_seg = 7'h7F; m_ack = 1'b0; m_frame = 1'b0;
    end else begin
      int p, d, ph;
      logic dark;
      p = m_e % FRAME; d = p / SLOT; ph = p % SLOT;
      m_frame = (p == FRAME - 1);
      m_ack   = m_frame && upd_req;
      if (ph == BL - 1) begin
        dark  = blank_mask[d] || (lz_en && d >= 1 && (m_sh >> (4 * d)) == 24'h0);
        m_an  = ~(6'b000001 << d);
        m_seg = dark ? 7'h7F : dec(m_sh[4*d +: 4]);
      end else if (ph == SLOT - 1) begin
        m_an = 6'h3F; m_seg = 7'h7F;
      end
      if (m_ack) m_sh = digits_in;
      m_e = m_e + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int d;
    d = (m_e % FRAME) / SLOT;
    chk("an_n", an_n, m_an);
    chk("seg_out", seg_out, m_seg);
    chk("upd_ack", upd_ack, m_ack);
    chk("frame_done", frame_done, m_frame);
    chk("hex_out", hex_out, m_sh[4*d +: 4]);
  end

  logic [6:0] cap_seg [ND];
  logic [3:0] cap_hex [ND];

  task automatic scan_frame();
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++)
        if (an_n == ~(6'b000001 << k)) begin cap_seg[k] = seg_out; cap_hex[k] = hex_out; end
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!upd_ack && n < 200) begin @(negedge clk); n++; end
    if (!upd_ack) begin errors++; $display("FAIL ack_timeout: no upd_ack within 200 cycles"); end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_an", an_n, 6'h3F);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_hex", hex_out, 0);
    chk("rst_ack", upd_ack, 0);
    rst_n = 1'b1;

    // Reset scan and first load.
    digits_in = 24'h123456; upd_req = 1'b1;
    wait_ack(n);
    chk("first_ack_cycle", n, 36);
    chk("first_frame_done", frame_done, 1);
    upd_req = 1'b0;
    scan_frame();
    for (int k = 0; k < ND; k++) chk("scan_hex", cap_hex[k], 6 - k);

    // Leading zero suppression.
    digits_in = 24'h000705; lz_en = 1'b1; upd_req = 1'b1;
    repeat (FRAME) @(negedge clk);
    wait_ack(n);
    chk("lz_ack_cycle", n, 0);
    upd_req = 1'b0;
    scan_frame();
    chk("lz_d5", cap_seg[5], 7'h7F);
    chk("lz_d3", cap_seg[3], 7'h7F);
    chk("lz_d2", cap_seg[2], 7'h78);
    chk("lz_d1", cap_seg[1], 7'h40);
    chk("lz_d0", cap_seg[0], 7'h12);
    lz_en = 1'b0;
    scan_frame();
    chk("nolz_d5", cap_seg[5], 7'h40);

    // Masking, then clearing the mask mid-frame.
    blank_mask = 6'b000011;
    scan_frame();
    chk("mask_d0", cap_seg[0], 7'h7F);
    chk("mask_d1", cap_seg[1], 7'h7F);
    chk("mask_d2", cap_seg[2], 7'h78);
    repeat (18) @(negedge clk);
    blank_mask = 6'b000011;
    repeat (18) @(negedge clk);
    blank_mask = 6'b001111;
    repeat (9) @(negedge clk);
    blank_mask = 6'b000000;
    repeat (27) @(negedge clk);

    // No tearing without a request; request mid-frame loads at next boundary.
    digits_in = 24'hABCDEF;
    scan_frame();
    scan_frame();
    chk("tear_d0", cap_hex[0], 5);
    chk("tear_d2", cap_hex[2], 7);
    repeat (10) @(negedge clk);
    upd_req = 1'b1;
    wait_ack(n);
    chk("midreq_ack_cycle", n, 26);

    // Continuous request.
    wait_ack(n);
    chk("cont_ack_dummy_start", n, 0);
    @(negedge clk);
    wait_ack(n);
    chk("cont_gap1", n, 35);
    @(negedge clk);
    wait_ack(n);
    chk("cont_gap2", n, 35);
    upd_req = 1'b0;
    scan_frame();
    chk("new_d0", cap_hex[0], 4'hF);
    chk("new_d5", cap_hex[5], 4'hA);

    // Asynchronous reset during digit 3 dwell.
    repeat (21) @(negedge clk);
    chk("pre_rst_an", an_n, 6'b110111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", an_n, 6'h3F);
    chk("async_rst_seg", seg_out, 7'h7F);
    chk("async_rst_hex", hex_out, 0);
    chk("async_rst_frame", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("restart_an", an_n, 6'b111110);
    chk("restart_hex", hex_out, 0);
    repeat (FRAME) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the digital clock's seven-segment display. It shares one hex-to-7-segment decoder across `NUM_DIGITS` common-anode digits. It holds a shadow copy of the digit values, updated only at frame boundaries through a req/ack handshake. It steps through the digits with a dead-time blanking interval between them, and drives the active-low anode and segment lines to the board pins.

## Interface
- `NUM_DIGITS`, 6: number of digits scanned. Legal range 2..8.
- `DWELL`, 1000: cycles each digit is lit. Must be at least 2.
- `BLANK`, 16: dead-time cycles between digits, with all anodes off. Must be at least 1.
- `clk`  in  1  the single clock. All state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `digits_in`  in  4*NUM_DIGITS  new digit values. Nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant and rightmost.
- `upd_req`  in  1  level request to load `digits_in` into the shadow register.
- `upd_ack`  out  1  one-cycle pulse: shadow loaded from `digits_in` on this cycle's edge.
- `lz_en`  in  1  enables leading-zero suppression.
- `blank_mask`  in  NUM_DIGITS  bit i = 1 forces digit i dark, for blinking during set mode.
- `hex_out`  out  4  nibble to the shared decoder input.
- `seg_in`  in  7  decoder output, active-low segments g..a.
- `seg_out`  out  7  registered segments to the pins, active-low.
- `an_n`  out  NUM_DIGITS  registered anode enables, active-low, at most one bit low.
- `frame_done`  out  1  one-cycle pulse at the end of each full scan.

## Operation
- **State** consists of:
  - FSM state {S_BLANK, S_ON};
  - digit index `idx` (0..NUM_DIGITS-1);
  - dwell/blank counter `cnt`;
  - shadow register `shadow` (4*NUM_DIGITS bits).
- **Reset values:**
  - state S_BLANK, `idx`=0, `cnt`=0, `shadow`=0;
  - `an_n`=all ones, `seg_out`=7'h7F;
  - `upd_ack`=0, `frame_done`=0;
  - `hex_out`=0 (follows from `shadow`=0, `idx`=0).
- **`hex_out`** is combinational, equal to `shadow` nibble `idx`. It is stable for the whole S_BLANK interval, so the decoder settles before capture.
- **S_BLANK:**
  - `an_n` all ones and `seg_out`=7'h7F.
  - `cnt` counts 0..BLANK-1.
  - At `cnt`=BLANK-1: go to S_ON, `cnt`←0, and load `an_n` with only bit `idx` low.
  - On that same edge, `seg_out`←7'h7F if digit `idx` is suppressed or masked, otherwise `seg_in`.
- **S_ON:**
  - `an_n` and `seg_out` are held constant.
  - `cnt` counts 0..DWELL-1.
  - At `cnt`=DWELL-1: go to S_BLANK, `cnt`←0, `an_n`←all ones, `seg_out`←7'h7F.
  - On the same edge, `idx` increments, wrapping from NUM_DIGITS-1 to 0.
- **Frame boundary** is the S_ON→S_BLANK edge with `idx`=NUM_DIGITS-1. On this edge:
  - `frame_done` pulses for one cycle.
  - If `upd_req`=1: `shadow`←`digits_in` and `upd_ack` pulses for one cycle.
- **Update handshake:**
  - The requester holds `upd_req` and `digits_in` stable until it sees `upd_ack`.
  - `upd_req` sampled at 0 on the boundary means no load.
  - `upd_req` held high means a reload every frame.
  - `digits_in` is never sampled outside the boundary edge.
- **Leading-zero suppression:**
  - Digit i (i ≥ 1) is suppressed when `lz_en`=1 and `shadow` nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - Suppression is evaluated on `shadow`, never on `digits_in`.
- **Masking:** `blank_mask` is sampled on the S_BLANK→S_ON edge only. A masked digit still drives its anode low, with segments 7'h7F, so duty cycle stays uniform.

## Timing
- Each digit slot is BLANK+DWELL cycles; the frame period is NUM_DIGITS*(BLANK+DWELL) cycles.
- After `rst_n` rises:
  - the first `an_n` low (digit 0) appears BLANK edges later;
  - the first `frame_done` pulse appears NUM_DIGITS*(BLANK+DWELL) edges later.
- The shadow update is visible on `hex_out` in the same cycle that `upd_ack`=1. It is displayed from digit 0 of the next frame, with no torn frame.
- An `upd_req` rising in the boundary cycle itself is accepted.
- Anode overlap never occurs: every anode change passes through at least one all-ones cycle (BLANK ≥ 1).
- `rst_n` asserted mid-scan:
  - all registers, outputs included, take their reset values immediately, without waiting for a clock;
  - any pending update is lost;
  - `upd_ack` and `frame_done` drop at once.

## Test plan
Bench parameters: NUM_DIGITS=6, DWELL=4, BLANK=2.
- **Reset scan:** reset, then `upd_req`=1 with `digits_in`=24'h123456 held until ack → `upd_ack` and `frame_done` pulse together at cycle 36. In the next frame, `an_n` walks 6'b111110…6'b011111 with 2 all-ones cycles between digits, and `hex_out` reads 6,5,4,3,2,1.
- **Leading zeros:** `digits_in`=24'h000705, `lz_en`=1, loaded → digits 5,4,3 dark (`seg_out`=7'h7F, anode still low); digits 2,1,0 show 7, 0, 5. With `lz_en`=0, digits 5,4,3 show decoder "0".
- **Mask:** `blank_mask`=6'b000011 → digits 0 and 1 dark, digits 2..5 normal. Clearing the mask mid-frame affects only digits not yet started.
- **No tearing:** change `digits_in` mid-frame without `upd_req` → display unchanged for the following frames. Assert `upd_req` → load and ack occur only on the next boundary.
- **Reset mid-operation:** pull `rst_n` low during S_ON of digit 3 → `an_n`=6'h3F and `seg_out`=7'h7F in the same cycle, before any clock edge. After release, the scan restarts at digit 0 and `hex_out`=0.
- **Continuous request:** `upd_req` held high → `upd_ack` pulses every 36 cycles, coincident with `frame_done`.
